// File: rtl/axi_pkg.sv
// Shared AXI constants and FSM state types for the scratch SRAM slave.
package axi_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] SIZE_4B     = 3'b010;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;
endpackage

// File: rtl/axi_sram_slave_mem.sv
// Word-addressed scratch array: one byte-strobed write port, one registered read port.
module axi_sram_slave_mem #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [31:0]           wdata,
  input  logic [3:0]            wstrb,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [31:0]           rdata
);
  logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];

  // Read and write share one block so a same-cycle collision returns the old word.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 INCR-burst slave over a local SRAM with independent read and write FSMs.
// Optional AXI_SLV_BACKPRESSURE_EN adds LFSR-driven ready/valid gating.
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  awid_i,
  input  logic [31:0] awaddr_i,
  input  logic [3:0]  awlen_i,
  input  logic [2:0]  awsize_i,
  input  logic [1:0]  awburst_i,
  input  logic        awvalid_i,
  output logic        awready_o,
  input  logic [3:0]  wid_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wstrb_i,
  input  logic        wlast_i,
  input  logic        wvalid_i,
  output logic        wready_o,
  output logic [3:0]  bid_o,
  output logic [1:0]  bresp_o,
  output logic        bvalid_o,
  input  logic        bready_i,
  input  logic [3:0]  arid_i,
  input  logic [31:0] araddr_i,
  input  logic [3:0]  arlen_i,
  input  logic [2:0]  arsize_i,
  input  logic [1:0]  arburst_i,
  input  logic        arvalid_i,
  output logic        arready_o,
  output logic [3:0]  rid_o,
  output logic [31:0] rdata_o,
  output logic [1:0]  rresp_o,
  output logic        rlast_o,
  output logic        rvalid_o,
  input  logic        rready_i
);
  localparam int unsigned MEM_SHIFT = DEPTH_LOG2 + 2;

  function automatic logic in_range(input logic [31:0] a);
    logic [32:0] off;
    off = {1'b0, a} - {1'b0, BASE_ADDR};
    return !off[32] && ((off[31:0] >> MEM_SHIFT) == 32'd0);
  endfunction

  function automatic logic [DEPTH_LOG2-1:0] word_idx(input logic [31:0] a);
    return DEPTH_LOG2'((a - BASE_ADDR) >> 2);
  endfunction

  logic bp_ok;

`ifdef AXI_SLV_BACKPRESSURE_EN
  logic [7:0] lfsr_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= 8'hA5;
    else        lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end
  assign bp_ok = lfsr_q[0];
`else
  assign bp_ok = 1'b1;
`endif

  logic unused_sigs;
  assign unused_sigs = ^wid_i;

  // ---------------- write channel ----------------
  w_state_t    w_state, w_state_d;
  logic [3:0]  w_id_q, w_len_q, w_cnt_q;
  logic [31:0] w_addr_q;
  logic        w_err_q, w_legal_q;
  logic        aw_hs, w_hs, w_beat_last, aw_legal, mem_we;

  assign aw_legal    = (awsize_i == SIZE_4B) && (awburst_i == BURST_INCR);
  assign w_beat_last = (w_cnt_q == w_len_q);
  assign aw_hs       = awvalid_i && awready_o;
  assign w_hs        = wvalid_i && wready_o;
  assign mem_we      = w_hs && w_legal_q && in_range(w_addr_q);

  always_comb begin
    w_state_d = w_state;
    awready_o = 1'b0;
    wready_o  = 1'b0;
    bvalid_o  = 1'b0;
    case (w_state)
      W_IDLE: begin
        awready_o = bp_ok;
        if (awvalid_i && bp_ok) w_state_d = W_DATA;
      end
      W_DATA: begin
        wready_o = bp_ok;
        if (wvalid_i && bp_ok && w_beat_last) w_state_d = W_RESP;
      end
      W_RESP: begin
        bvalid_o = 1'b1;
        if (bready_i) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state   <= W_IDLE;
      w_id_q    <= '0;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_err_q   <= 1'b0;
      w_legal_q <= 1'b0;
    end else begin
      w_state <= w_state_d;
      if (aw_hs) begin
        w_id_q    <= awid_i;
        w_addr_q  <= awaddr_i;
        w_len_q   <= awlen_i;
        w_cnt_q   <= '0;
        w_legal_q <= aw_legal;
        w_err_q   <= !aw_legal;
      end
      if (w_hs) begin
        w_addr_q <= w_addr_q + 32'd4;
        w_cnt_q  <= w_cnt_q + 4'd1;
        w_err_q  <= w_err_q || !in_range(w_addr_q) || (wlast_i != w_beat_last);
      end
    end
  end

  assign bid_o   = w_id_q;
  assign bresp_o = (w_state == W_RESP && w_err_q) ? RESP_SLVERR : RESP_OKAY;

  // ---------------- read channel ----------------
  r_state_t    r_state, r_state_d;
  logic [3:0]  r_id_q, r_len_q, r_cnt_q, r_cnt_nxt;
  logic [31:0] r_addr_q, r_load_addr, mem_rdata;
  logic        r_legal_q, rvalid_q, rlast_q, rd_ok_q;
  logic [1:0]  rresp_q;
  logic        r_load, r_ok, ar_legal;

  assign ar_legal  = (arsize_i == SIZE_4B) && (arburst_i == BURST_INCR);
  assign r_cnt_nxt = r_cnt_q + 4'd1;

  // A beat is (re)loaded on AR accept, after a non-last R handshake, or
  // after a masked gap between beats.
  always_comb begin
    r_state_d   = r_state;
    arready_o   = 1'b0;
    r_load      = 1'b0;
    r_load_addr = r_addr_q;
    r_ok        = r_legal_q && in_range(r_addr_q);
    case (r_state)
      R_IDLE: begin
        arready_o   = bp_ok;
        r_load_addr = araddr_i;
        r_ok        = ar_legal && in_range(araddr_i);
        if (arvalid_i && bp_ok) begin
          r_load    = 1'b1;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (rvalid_q && rready_i) begin
          if (rlast_q) r_state_d = R_IDLE;
          else         r_load    = bp_ok;
        end else if (!rvalid_q) begin
          r_load = bp_ok;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= R_IDLE;
      r_id_q    <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_addr_q  <= '0;
      r_legal_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rd_ok_q   <= 1'b0;
      rresp_q   <= RESP_OKAY;
    end else begin
      r_state <= r_state_d;
      if (r_load) begin
        rvalid_q <= 1'b1;
        rd_ok_q  <= r_ok;
        rresp_q  <= r_ok ? RESP_OKAY : RESP_SLVERR;
        r_addr_q <= r_load_addr + 32'd4;
        if (r_state == R_IDLE) begin
          r_id_q    <= arid_i;
          r_len_q   <= arlen_i;
          r_legal_q <= ar_legal;
          r_cnt_q   <= '0;
          rlast_q   <= (arlen_i == 4'd0);
        end else begin
          r_cnt_q <= r_cnt_nxt;
          rlast_q <= (r_cnt_nxt == r_len_q);
        end
      end else if (rvalid_q && rready_i) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  assign rid_o    = r_id_q;
  assign rvalid_o = rvalid_q;
  assign rlast_o  = rvalid_q && rlast_q;
  assign rresp_o  = rresp_q;
  assign rdata_o  = rd_ok_q ? mem_rdata : 32'd0;

  axi_sram_slave_mem #(.DEPTH_LOG2(DEPTH_LOG2)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (word_idx(w_addr_q)),
    .wdata (wdata_i),
    .wstrb (wstrb_i),
    .re    (r_load),
    .raddr (word_idx(r_load_addr)),
    .rdata (mem_rdata)
  );
endmodule

// File: tb/tb_axi_sram_slave.sv
// Self-checking bench for axi_sram_slave: vector table, directed corner cases, random bursts vs. a word-array model.
module tb_axi_sram_slave;
  localparam int DL2   = 6;
  localparam int WORDS = 1 << DL2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  awid_i = '0;
  logic [31:0] awaddr_i = '0;
  logic [3:0]  awlen_i = '0;
  logic [2:0]  awsize_i = '0;
  logic [1:0]  awburst_i = '0;
  logic        awvalid_i = 1'b0;
  logic        awready_o;
  logic [3:0]  wid_i = '0;
  logic [31:0] wdata_i = '0;
  logic [3:0]  wstrb_i = '0;
  logic        wlast_i = 1'b0;
  logic        wvalid_i = 1'b0;
  logic        wready_o;
  logic [3:0]  bid_o;
  logic [1:0]  bresp_o;
  logic        bvalid_o;
  logic        bready_i = 1'b0;
  logic [3:0]  arid_i = '0;
  logic [31:0] araddr_i = '0;
  logic [3:0]  arlen_i = '0;
  logic [2:0]  arsize_i = '0;
  logic [1:0]  arburst_i = '0;
  logic        arvalid_i = 1'b0;
  logic        arready_o;
  logic [3:0]  rid_o;
  logic [31:0] rdata_o;
  logic [1:0]  rresp_o;
  logic        rlast_o;
  logic        rvalid_o;
  logic        rready_i = 1'b0;

  always #5 clk = ~clk;

  axi_sram_slave #(.DEPTH_LOG2(DL2), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .awid_i(awid_i), .awaddr_i(awaddr_i), .awlen_i(awlen_i), .awsize_i(awsize_i),
    .awburst_i(awburst_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
    .wid_i(wid_i), .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wlast_i(wlast_i),
    .wvalid_i(wvalid_i), .wready_o(wready_o),
    .bid_o(bid_o), .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
    .arid_i(arid_i), .araddr_i(araddr_i), .arlen_i(arlen_i), .arsize_i(arsize_i),
    .arburst_i(arburst_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
    .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o), .rlast_o(rlast_o),
    .rvalid_o(rvalid_o), .rready_i(rready_i)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] model [WORDS];
  logic [31:0] wbuf_d [16];
  logic [3:0]  wbuf_s [16];
  logic [31:0] last_rdata;
  logic        pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  len;
    logic [31:0] base;
    logic [3:0]  strb;
    logic [1:0]  exp_bresp;
  } vec_t;
  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    return a < 32'(WORDS * 4);
  endfunction

  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int bad_beat,
                           input int send_beats, output logic [1:0] resp);
    bit legal, err;
    int n;
    logic [31:0] a;
    logic [DL2-1:0] idx;
    legal = (size == 3'b010) && (burst == 2'b01);
    err   = !legal;
    resp  = 2'b11;
    @(negedge clk);
    awid_i = id; awaddr_i = addr; awlen_i = len; awsize_i = size; awburst_i = burst; awvalid_i = 1'b1;
    n = 0;
    while (!awready_o && n < 100) begin @(negedge clk); n++; end
    if (!awready_o) begin
      check("aw_ready_timeout", 32'(awready_o), 32'd1);
      awvalid_i = 1'b0;
      return;
    end
    @(posedge clk); @(negedge clk);
    awvalid_i = 1'b0;
    for (int i = 0; i <= int'(len) && i < send_beats; i++) begin
      a = addr + 32'(4 * i);
      wdata_i = wbuf_d[i]; wstrb_i = wbuf_s[i];
      wlast_i = (i == int'(len)) != (i == bad_beat);
      wvalid_i = 1'b1;
      n = 0;
      while (!wready_o && n < 100) begin @(negedge clk); n++; end
      if (!wready_o) begin
        check("w_ready_timeout", 32'(wready_o), 32'd1);
        wvalid_i = 1'b0;
        return;
      end
      @(posedge clk);
      if (legal && in_rng(a)) begin
        idx = a[DL2+1:2];
        for (int b = 0; b < 4; b++)
          if (wbuf_s[i][b]) model[idx][8*b +: 8] = wbuf_d[i][8*b +: 8];
      end
      if (!in_rng(a) || (wlast_i != (i == int'(len)))) err = 1'b1;
      @(negedge clk);
      wvalid_i = 1'b0; wlast_i = 1'b0;
    end
    if (send_beats <= int'(len)) return;
    bready_i = 1'b1;
    n = 0;
    while (!bvalid_o && n < 100) begin @(negedge clk); n++; end
    if (!bvalid_o) begin
      check("b_valid_timeout", 32'(bvalid_o), 32'd1);
      bready_i = 1'b0;
      return;
    end
    resp = bresp_o;
    check("bid", 32'(bid_o), 32'(id));
    check("bresp_model", 32'(bresp_o), err ? 32'd2 : 32'd0);
    @(posedge clk); @(negedge clk);
    bready_i = 1'b0;
    check("bvalid_drop", 32'(bvalid_o), 32'd0);
  endtask

  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int mode,
                          output int cycles);
    bit legal, ok, held;
    int n, beat, cyc;
    logic [31:0] a, hd;
    logic [1:0] hr;
    logic hl;
    legal = (size == 3'b010) && (burst == 2'b01);
    held = 1'b0; hd = '0; hr = '0; hl = 1'b0;
    cycles = -1;
    @(negedge clk);
    arid_i = id; araddr_i = addr; arlen_i = len; arsize_i = size; arburst_i = burst; arvalid_i = 1'b1;
    n = 0;
    while (!arready_o && n < 100) begin @(negedge clk); n++; end
    if (!arready_o) begin
      check("ar_ready_timeout", 32'(arready_o), 32'd1);
      arvalid_i = 1'b0;
      return;
    end
    @(posedge clk); @(negedge clk);
    arvalid_i = 1'b0;
    beat = 0; cyc = 0;
    while (beat <= int'(len) && cyc < 400) begin
      rready_i = (mode == 0) ? 1'b1 : (mode == 1) ? pat[cyc % 4] : 1'($urandom_range(0, 1));
      if (rvalid_o) begin
        if (held) begin
          check("r_hold_data", rdata_o, hd);
          check("r_hold_resp", 32'(rresp_o), 32'(hr));
          check("r_hold_last", 32'(rlast_o), 32'(hl));
        end
        if (rready_i) begin
          a  = addr + 32'(4 * beat);
          ok = legal && in_rng(a);
          check("rdata", rdata_o, ok ? model[a[DL2+1:2]] : 32'd0);
          check("rresp", 32'(rresp_o), ok ? 32'd0 : 32'd2);
          check("rlast", 32'(rlast_o), 32'(beat == int'(len)));
          check("rid", 32'(rid_o), 32'(id));
          last_rdata = rdata_o;
          beat++;
          held = 1'b0;
        end else begin
          held = 1'b1; hd = rdata_o; hr = rresp_o; hl = rlast_o;
        end
      end
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    rready_i = 1'b0;
    if (beat <= int'(len)) check("r_beat_timeout", 32'(beat), 32'(int'(len) + 1));
    check("rvalid_after", 32'(rvalid_o), 32'd0);
    cycles = cyc;
  endtask

  initial begin
    logic [1:0] resp;
    int cyc;
    logic [31:0] old5, new5, raddr, waddr;
    logic [3:0] rlen, wlen;
    logic [2:0] sz;
    logic [1:0] bt;

    // Reset state, checked while reset is held.
    #12;
    check("rst_awready", 32'(awready_o), 32'd1);
    check("rst_arready", 32'(arready_o), 32'd1);
    check("rst_wready",  32'(wready_o),  32'd0);
    check("rst_bvalid",  32'(bvalid_o),  32'd0);
    check("rst_rvalid",  32'(rvalid_o),  32'd0);
    check("rst_rlast",   32'(rlast_o),   32'd0);
    check("rst_bresp",   32'(bresp_o),   32'd0);
    check("rst_rresp",   32'(rresp_o),   32'd0);
    check("rst_rdata",   rdata_o,        32'd0);
    check("rst_bid",     32'(bid_o),     32'd0);
    check("rst_rid",     32'(rid_o),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Preload the whole array so the model never holds unknown words.
    for (int k = 0; k < WORDS / 16; k++) begin
      for (int i = 0; i < 16; i++) begin wbuf_d[i] = $urandom; wbuf_s[i] = 4'hF; end
      axi_write(4'd0, 32'(64 * k), 4'd15, 3'b010, 2'b01, -1, 99, resp);
    end

    vecs[0] = '{32'h40,  4'd3,  32'd1,         4'hF, 2'b00};
    vecs[1] = '{32'h80,  4'd15, 32'hA000_0000, 4'hF, 2'b00};
    vecs[2] = '{32'hF8,  4'd3,  32'hB000_0000, 4'hF, 2'b10};
    vecs[3] = '{32'h100, 4'd0,  32'hC000_0000, 4'hF, 2'b10};
    vecs[4] = '{32'h10,  4'd1,  32'hD000_0000, 4'h3, 2'b00};
    vecs[5] = '{32'hFC,  4'd0,  32'hE000_0000, 4'hC, 2'b00};
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 16; i++) begin wbuf_d[i] = vecs[v].base + 32'(i); wbuf_s[i] = vecs[v].strb; end
      axi_write(4'(v + 1), vecs[v].addr, vecs[v].len, 3'b010, 2'b01, -1, 99, resp);
      check("vec_bresp", 32'(resp), 32'(vecs[v].exp_bresp));
      axi_read(4'(v + 8), vecs[v].addr, vecs[v].len, 3'b010, 2'b01, 0, cyc);
      check("vec_no_bubble", 32'(cyc), 32'(int'(vecs[v].len) + 1));
    end

    // Byte-strobe merge.
    wbuf_d[0] = 32'hFFFF_FFFF; wbuf_s[0] = 4'hF;
    axi_write(4'd2, 32'h0, 4'd0, 3'b010, 2'b01, -1, 99, resp);
    wbuf_d[0] = 32'h1234_5678; wbuf_s[0] = 4'b0101;
    axi_write(4'd2, 32'h0, 4'd0, 3'b010, 2'b01, -1, 99, resp);
    axi_read(4'd3, 32'h0, 4'd0, 3'b010, 2'b01, 0, cyc);
    check("strobe_merge", last_rdata, 32'hFF34_FF78);

    // Early wlast straddling the top of memory; word 0 must not be aliased.
    wbuf_d[0] = 32'h5555_0001; wbuf_d[1] = 32'h5555_0002; wbuf_s[0] = 4'hF; wbuf_s[1] = 4'hF;
    axi_write(4'd4, 32'hFC, 4'd1, 3'b010, 2'b01, 0, 99, resp);
    check("early_wlast_slverr", 32'(resp), 32'd2);
    axi_read(4'd5, 32'hFC, 4'd1, 3'b010, 2'b01, 0, cyc);
    axi_read(4'd5, 32'h0, 4'd0, 3'b010, 2'b01, 0, cyc);
    check("no_alias_word0", last_rdata, 32'hFF34_FF78);
    axi_read(4'd6, 32'hF8, 4'd3, 3'b010, 2'b01, 0, cyc);

    // Stalled 8-beat read.
    axi_read(4'd7, 32'h80, 4'd7, 3'b010, 2'b01, 1, cyc);

    // Same-cycle write and read-load of word 5.
    old5 = model[5];
    new5 = ~old5 ^ 32'h0F0F_0001;
    @(negedge clk);
    awid_i = 4'd9; awaddr_i = 32'h14; awlen_i = 4'd0; awsize_i = 3'b010; awburst_i = 2'b01; awvalid_i = 1'b1;
    @(posedge clk); @(negedge clk);
    awvalid_i = 1'b0;
    wdata_i = new5; wstrb_i = 4'hF; wlast_i = 1'b1; wvalid_i = 1'b1;
    arid_i = 4'd10; araddr_i = 32'h14; arlen_i = 4'd0; arsize_i = 3'b010; arburst_i = 2'b01; arvalid_i = 1'b1;
    check("coll_wready", 32'(wready_o), 32'd1);
    check("coll_arready", 32'(arready_o), 32'd1);
    @(posedge clk); @(negedge clk);
    wvalid_i = 1'b0; wlast_i = 1'b0; arvalid_i = 1'b0;
    check("coll_rvalid", 32'(rvalid_o), 32'd1);
    check("coll_old_data", rdata_o, old5);
    rready_i = 1'b1; bready_i = 1'b1;
    check("coll_bvalid", 32'(bvalid_o), 32'd1);
    @(posedge clk); @(negedge clk);
    rready_i = 1'b0; bready_i = 1'b0;
    model[5] = new5;
    axi_read(4'd11, 32'h14, 4'd0, 3'b010, 2'b01, 0, cyc);
    check("coll_new_data", last_rdata, new5);

    // Reset in the middle of a 4-beat write.
    for (int i = 0; i < 4; i++) begin wbuf_d[i] = 32'h7700_0000 + 32'(i); wbuf_s[i] = 4'hF; end
    axi_write(4'd12, 32'h20, 4'd3, 3'b010, 2'b01, -1, 2, resp);
    check("pre_rst_wready", 32'(wready_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_wready", 32'(wready_o), 32'd0);
    check("mid_rst_bvalid", 32'(bvalid_o), 32'd0);
    check("mid_rst_awready", 32'(awready_o), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    axi_read(4'd13, 32'h20, 4'd3, 3'b010, 2'b01, 0, cyc);
    for (int i = 0; i < 4; i++) wbuf_d[i] = 32'h8800_0000 + 32'(i);
    axi_write(4'd14, 32'h20, 4'd3, 3'b010, 2'b01, -1, 99, resp);
    check("post_rst_bresp", 32'(resp), 32'd0);
    axi_read(4'd15, 32'h20, 4'd3, 3'b010, 2'b01, 2, cyc);

    // Randomized bursts against the model.
    for (int t = 0; t < 40; t++) begin
      waddr = 32'($urandom_range(0, 70) * 4);
      wlen  = 4'($urandom_range(0, 15));
      sz    = ($urandom_range(0, 9) == 0) ? 3'b001 : 3'b010;
      bt    = ($urandom_range(0, 9) == 0) ? 2'b00 : 2'b01;
      for (int i = 0; i < 16; i++) begin wbuf_d[i] = $urandom; wbuf_s[i] = 4'($urandom_range(0, 15)); end
      axi_write(4'($urandom_range(0, 15)), waddr, wlen, sz, bt,
                ($urandom_range(0, 7) == 0) ? $urandom_range(0, int'(wlen)) : -1, 99, resp);
      raddr = 32'($urandom_range(0, 70) * 4);
      rlen  = 4'($urandom_range(0, 15));
      sz    = ($urandom_range(0, 9) == 0) ? 3'b000 : 3'b010;
      bt    = ($urandom_range(0, 9) == 0) ? 2'b10 : 2'b01;
      axi_read(4'($urandom_range(0, 15)), raddr, rlen, sz, bt, $urandom_range(0, 2), cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
AXI3-style slave memory model and on-chip scratch SRAM, targeted by the DMA engines over the same 32-bit AR/R/AW/W/B interface they drive as master.
- Independent read and write FSMs serve INCR bursts of 1–16 beats from a local word-addressed register array.
- Used as the DMA target in block-level benches and as a small integration SRAM.

Parameters:
DEPTH_LOG2, 10, log2 of memory depth in 32-bit words
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4-byte aligned

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
awid_i  in  4  write burst ID
awaddr_i  in  32  write start byte address
awlen_i  in  4  write beats minus 1
awsize_i  in  3  beat size; only 3'b010 legal
awburst_i  in  2  burst type; only 2'b01 (INCR) legal
awvalid_i  in  1  AW valid
awready_o  out  1  AW ready
wid_i  in  4  write data ID, ignored
wdata_i  in  32  write data
wstrb_i  in  4  byte enables
wlast_i  in  1  last write beat
wvalid_i  in  1  W valid
wready_o  out  1  W ready
bid_o  out  4  response ID
bresp_o  out  2  response: 2'b00 OKAY, 2'b10 SLVERR
bvalid_o  out  1  B valid
bready_i  in  1  B ready
arid_i  in  4  read burst ID
araddr_i  in  32  read start byte address
arlen_i  in  4  read beats minus 1
arsize_i  in  3  beat size
arburst_i  in  2  burst type
arvalid_i  in  1  AR valid
arready_o  out  1  AR ready
rid_o  out  4  read ID
rdata_o  out  32  read data
rresp_o  out  2  read response
rlast_o  out  1  last read beat
rvalid_o  out  1  R valid
rready_i  in  1  R ready

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - Both FSMs go to IDLE.
  - awready_o=1, arready_o=1; wready_o, bvalid_o, rvalid_o, rlast_o = 0.
  - bresp_o, rresp_o, rdata_o, bid_o, rid_o = 0.
  - Memory contents are not reset.
- Reset mid-burst aborts the burst silently. Beats already written remain in memory.
- Word index = (addr - BASE_ADDR)[DEPTH_LOG2+1:2]. A beat is in range iff BASE_ADDR <= addr < BASE_ADDR + 4*2^DEPTH_LOG2.
- Address advances +4 per beat. No 4 KB boundary check. The address is not wrapped.
- Write FSM, states W_IDLE, W_DATA, W_RESP:
  - W_IDLE: awready_o=1. On AW handshake, capture awid, awaddr and awlen; clear beat count and error flag; go to W_DATA next cycle.
  - W_DATA: wready_o=1, awready_o=0.
    - Each W handshake writes the bytes enabled by wstrb_i, only if the beat is in range and the burst is legal.
    - Error flag is set if any of: out-of-range beat; awsize≠2 or awburst≠INCR; wlast_i≠(count==awlen).
    - When count==awlen, go to W_RESP; otherwise increment count.
  - W_RESP: bvalid_o=1, bid_o=captured awid, bresp_o=SLVERR if error flag else OKAY. On bready_i, go to W_IDLE.
  - Minimum AW-to-B turnaround: AW at cycle t, first W accepted at t+1, bvalid_o at t+2 for a 1-beat burst.
- Read FSM, states R_IDLE, R_DATA:
  - R_IDLE: arready_o=1. On AR handshake:
    - capture arid and arlen;
    - register rdata_o ← mem[araddr] (0 if out of range or illegal burst);
    - set rresp_o accordingly;
    - set rlast_o = (arlen==0), rvalid_o=1;
    - go to R_DATA. rvalid_o is therefore high in cycle t+1.
  - R_DATA: arready_o=0. rdata/rresp/rlast are held stable while rvalid_o is high and rready_i is low.
    - On R handshake with rlast_o=1: rvalid_o=0, go to R_IDLE.
    - On R handshake otherwise: load next word, and rlast_o=(next count==arlen).
  - Full throughput: one beat per cycle when rready_i stays high.
- Read/write collision: the memory is dual-access. If a write commits to word k in the same cycle rdata_o is loaded from word k, rdata_o gets the OLD value.
- Read and write bursts run fully concurrently. Each FSM accepts at most one outstanding burst.

Optional Feature:
AXI_SLV_BACKPRESSURE_EN
- Defined: an 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 8'hA5 on reset) advances every cycle. When LFSR[0]=0, it gates awready_o, arready_o and wready_o low, and masks rvalid_o low in R_DATA.
  - Data and response are held; no beat is lost.
  - Masking applies only between beats: once rvalid_o is high it is not dropped until the handshake.
- Undefined: no gating; behaviour exactly as above.

Decomposition:
Shared package axi_pkg:
- localparams RESP_OKAY=2'b00, RESP_SLVERR=2'b10, BURST_INCR=2'b01, SIZE_4B=3'b010;
- enum typedefs w_state_t and r_state_t.

Sub-module axi_sram_slave_mem holds the register array with one write port (byte strobes) and one synchronous read port. The two FSMs stay in the top module.

Test Plan:
1. AW addr 0x40 len 3, W data 1,2,3,4 strobe F, then AR 0x40 len 3 with rready held high → bresp OKAY; R beats 1,2,3,4, rlast on beat 4 only, rvalid at AR+1, no bubbles.
2. Write 0xFFFF_FFFF to 0x0, then write 0x1234_5678 with wstrb 4'b0101, read 0x0 → 0xFF34_FF78.
3. DEPTH_LOG2=4: AR addr 0x38 len 3 → beats 1–2 OKAY with memory data, beats 3–4 SLVERR with data 0. AW len 1 with wlast on beat 1 → SLVERR, memory unchanged where out of range.
4. rready_i toggling 1,0,0,1 during an 8-beat read → each beat held stable while stalled, 8 beats total, correct order.
5. Same-cycle write to word 5 and R load of word 5 → read returns old value; subsequent read returns new value.
6. Assert rst_n low mid-write after beat 2 of 4 → asynchronous clear of bvalid/wready, awready_o=1; beats 1–2 retained; next burst completes normally.
